// File: rtl/input_debounce_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_edge_pkg
// Description : Shared constants and helper functions for the debounce/edge
//               front end: edge-mode encodings, counter width and edge match.
// Revision    : 1.0 - initial release
// ============================================================================
package input_debounce_edge_pkg;

    // Edge-mode encodings for the EDGE_MODE parameter
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Stability counter width: max(1, clog2(cycles))
    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

    // True when a level transition to new_level should raise an event
    function automatic logic edge_match(input int mode, input logic new_level);
        case (mode)
            EDGE_RISE: return new_level;
            EDGE_FALL: return ~new_level;
            default:   return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_debounce_edge_db_channel.sv
`default_nettype none
// ============================================================================
// Module      : db_channel
// Description : Single-bit synchroniser, glitch-reject filter, stable-level
//               register and edge event pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module db_channel
    import input_debounce_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic level_o,
    output logic pulse_o,
    output logic pulse_set_o
);

    localparam int            c_CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic [c_CNT_W-1:0]     cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
        end
    end

    // Count consecutive disagreement; any agreement restarts the count
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (w_sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_CNT_MAX) begin
            level_d = w_sync;
            cnt_d   = '0;
            pulse_d = edge_match(EDGE_MODE, w_sync);
        end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    // Counter, accepted level and event pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o     = level_q;
    assign pulse_o     = pulse_q;
    assign pulse_set_o = pulse_d;

endmodule
`default_nettype wire

// File: rtl/input_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_edge
// Description : Multi-channel switch front end. Each channel is synchronised,
//               debounced and produces a one-cycle pulse on the selected edge.
//               Define INPUT_DEBOUNCE_EVT_LATCH_EN to add sticky per-channel
//               event flags (evt_pending_o) with clear inputs (evt_clr_i).
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce_edge
    import input_debounce_edge_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_i,
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    input  logic [N_CH-1:0] evt_clr_i,
    output logic [N_CH-1:0] evt_pending_o,
`endif
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] pulse_o,
    output logic            any_pulse_o
);

    logic [N_CH-1:0] w_pulse_set;
    logic            any_pulse_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .EDGE_MODE   (EDGE_MODE)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .sw_i        (sw_i[i]),
            .level_o     (level_o[i]),
            .pulse_o     (pulse_o[i]),
            .pulse_set_o (w_pulse_set[i])
        );
    end

    // Register the OR of next-cycle pulse conditions so it aligns with pulse_o
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= |w_pulse_set;
        end
    end

    assign any_pulse_o = any_pulse_q;

`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    logic [N_CH-1:0] evt_pending_q;
    logic [N_CH-1:0] evt_pending_d;

    // Sticky flags: a pulse sets the bit and overrides a simultaneous clear
    always_comb begin
        evt_pending_d = (evt_pending_q & ~evt_clr_i) | pulse_o;
    end

    // Event flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pending_q <= '0;
        end else begin
            evt_pending_q <= evt_pending_d;
        end
    end

    assign evt_pending_o = evt_pending_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce_edge
// Description : Self-checking bench. Three instances (rising, falling, both)
//               share stimulus; a history-window reference model predicts
//               level, pulse, any_pulse (and event flags when enabled).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce_edge;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    localparam int W = 39;
`else
    localparam int W = 27;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] sw    = '0;
    logic [2:0][N_CH-1:0] lvl;
    logic [2:0][N_CH-1:0] pul;
    logic [2:0]           anyp;
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    logic [N_CH-1:0]      evt_clr = '0;
    logic [2:0][N_CH-1:0] pend;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        input_debounce_edge #(
            .N_CH        (N_CH),
            .SYNC_STAGES (SYNC),
            .DB_CYCLES   (DB),
            .EDGE_MODE   (m)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .sw_i          (sw),
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
            .evt_clr_i     (evt_clr),
            .evt_pending_o (pend[m]),
`endif
            .level_o       (lvl[m]),
            .pulse_o       (pul[m]),
            .any_pulse_o   (anyp[m])
        );
    end

    // ---------------- reference model ----------------
    // Level flips at edge k when the synchronised value (sw sampled SYNC edges
    // earlier) disagreed with the level at every one of the last DB edges,
    // all of them after the previous flip.
    int                   k_q;
    int                   lc_q [N_CH];
    logic [N_CH-1:0]      hist [64];
    logic [N_CH-1:0]      e_lvl;
    logic [2:0][N_CH-1:0] e_pul;
    logic [2:0]           e_any;
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    logic [2:0][N_CH-1:0] e_pend;
`endif

    function automatic logic s_at(int ch, int j);
        return (j < SYNC) ? 1'b0 : hist[(j - SYNC) % 64][ch];
    endfunction

    function automatic logic accept(int ch, int k, logic cur, int lc);
        if (k - DB + 1 <= lc) return 1'b0;
        for (int j = k - DB + 1; j <= k; j++)
            if (s_at(ch, j) == cur) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic mode_ok(int m, logic new_lvl);
        if (m == 0) return new_lvl;
        if (m == 1) return !new_lvl;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= 0;
            e_lvl <= '0;
            e_pul <= '0;
            for (int c = 0; c < N_CH; c++) lc_q[c] <= -1;
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
            e_pend <= '0;
`endif
        end else begin
            hist[k_q % 64] <= sw;
            k_q <= k_q + 1;
            for (int c = 0; c < N_CH; c++) begin
                e_lvl[c] <= e_lvl[c] ^ accept(c, k_q, e_lvl[c], lc_q[c]);
                lc_q[c]  <= accept(c, k_q, e_lvl[c], lc_q[c]) ? k_q : lc_q[c];
                for (int m = 0; m < 3; m++)
                    e_pul[m][c] <= accept(c, k_q, e_lvl[c], lc_q[c]) && mode_ok(m, !e_lvl[c]);
            end
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
            for (int m = 0; m < 3; m++)
                e_pend[m] <= (e_pend[m] & ~evt_clr) | e_pul[m];
`endif
        end
    end

    always_comb begin
        e_any = '0;
        for (int m = 0; m < 3; m++) e_any[m] = |e_pul[m];
    end

    logic [W-1:0] obs;
    logic [W-1:0] expv;
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    assign obs  = {lvl, pul, anyp, pend};
    assign expv = {{3{e_lvl}}, e_pul, e_any, e_pend};
`else
    assign obs  = {lvl, pul, anyp};
    assign expv = {{3{e_lvl}}, e_pul, e_any};
`endif

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N_CH-1:0] sw_val);
        sw    = sw_val;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sw    = 4'hF;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if ({lvl, pul, anyp} !== 27'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: got %h expected 0", i, {lvl, pul, anyp});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
        n_chk++;
        if (lvl[0] !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_pre_level: got %h expected f", lvl[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({lvl, pul, anyp} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", {lvl, pul, anyp});
        end
        tick();
    endtask

    task automatic test_clean_rise();
        do_reset(4'h0);
        tick();
        tick();
        sw[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rise_model cyc %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 4 || i == 5 || i == 6) begin
                n_chk++;
                if ((i == 4 && (lvl[0][0] !== 1'b0 || pul[0] !== 4'h0)) ||
                    (i == 5 && (lvl[0][0] !== 1'b1 || pul[0] !== 4'h1 || anyp[0] !== 1'b1)) ||
                    (i == 6 && (lvl[0][0] !== 1'b1 || pul[0] !== 4'h0))) begin
                    n_fail++;
                    $display("FAIL rise_timing edge %0d: level %b pulse %h", i, lvl[0][0], pul[0]);
                end
            end
        end
        sw[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL fall_model cyc %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 4 || i == 5) begin
                n_chk++;
                if ((i == 4 && lvl[0][0] !== 1'b1) ||
                    (i == 5 && (lvl[0][0] !== 1'b0 || pul[0] !== 4'h0 || pul[1] !== 4'h1))) begin
                    n_fail++;
                    $display("FAIL fall_timing edge %0d: level %b pulse0 %h pulse1 %h",
                             i, lvl[0][0], pul[0], pul[1]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 6; i++) begin
                sw[1] = (i < 3);
                tick();
                seen |= pul[0][1] | pul[1][1] | pul[2][1];
                n_chk++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL glitch_model r%0d cyc %0d: got %h expected %h", r, i, obs, expv);
                end
            end
        end
        n_chk++;
        if (lvl[2][1] !== 1'b0 || seen !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_reject: level %b pulse_seen %b expected 0 0", lvl[2][1], seen);
        end
        sw[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL glitch_accept_model cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
        n_chk++;
        if (lvl[0][1] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_accept: level %b expected 1", lvl[0][1]);
        end
        sw[1] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_edge_modes();
        int cnt [3] = '{0, 0, 0};
        int first = -1;
        int last  = -1;
        for (int i = 0; i < 20; i++) begin
            sw[2] = (i < 10);
            tick();
            for (int m = 0; m < 3; m++) if (pul[m][2]) cnt[m]++;
            if (pul[2][2]) begin
                if (first < 0) first = i;
                last = i;
            end
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL edge_model cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
        n_chk++;
        if (cnt[0] != 1 || cnt[1] != 1 || cnt[2] != 2 || last - first != 10) begin
            n_fail++;
            $display("FAIL edge_counts: rise %0d fall %0d both %0d gap %0d expected 1 1 2 10",
                     cnt[0], cnt[1], cnt[2], last - first);
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_simultaneous();
        sw = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        sw = 4'hF;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL simul_model cyc %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 5 || i == 6) begin
                n_chk++;
                if ((i == 5 && (pul[0] !== 4'hF || anyp[0] !== 1'b1)) ||
                    (i == 6 && (pul[0] !== 4'h0 || anyp[0] !== 1'b0))) begin
                    n_fail++;
                    $display("FAIL simul_pulse edge %0d: pulse %h any %b", i, pul[0], anyp[0]);
                end
            end
        end
        sw = 4'h0;
        for (int i = 0; i < 10; i++) tick();
        sw = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (pul !== '0 || anyp !== 3'b0 || lvl !== '0) begin
                n_fail++;
                $display("FAIL simul_in_reset cyc %0d: pulse %h any %b", i, pul, anyp);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL simul_rel_model cyc %0d: got %h expected %h", i, obs, expv);
            end
            if (i == 5) begin
                n_chk++;
                if (pul[0] !== 4'hF || pul[2] !== 4'hF || lvl[0] !== 4'hF) begin
                    n_fail++;
                    $display("FAIL simul_rel_pulse: pulse %h level %h expected f f", pul[0], lvl[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold [N_CH];
        for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 8);
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    sw[c]   = ~sw[c];
                    hold[c] = $urandom_range(1, 8);
                end
            end
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_model cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
    endtask

`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    task automatic test_evt_latch();
        logic found = 1'b0;
        sw = 4'h0;
        evt_clr = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        evt_clr = 4'h0;
        sw[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL evt_set_model cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
        n_chk++;
        if (pend[0][3] !== 1'b1) begin
            n_fail++;
            $display("FAIL evt_held: pending %b expected 1", pend[0][3]);
        end
        evt_clr[3] = 1'b1;
        tick();
        n_chk++;
        if (pend[0][3] !== 1'b0 || obs !== expv) begin
            n_fail++;
            $display("FAIL evt_clear: pending %b expected 0", pend[0][3]);
        end
        sw[3] = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL evt_race_model cyc %0d: got %h expected %h", i, obs, expv);
            end
            if (pul[2][3]) begin
                found = 1'b1;
                tick();
                n_chk++;
                if (pend[2][3] !== 1'b1 || obs !== expv) begin
                    n_fail++;
                    $display("FAIL evt_set_wins: pending %b expected 1", pend[2][3]);
                end
            end
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL evt_race_timeout: pulse seen %b expected 1", found);
        end
        evt_clr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL evt_tail_model cyc %0d: got %h expected %h", i, obs, expv);
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_rise();
        test_glitch();
        test_edge_modes();
        test_simultaneous();
        test_random();
`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
        test_evt_latch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
